// File: rtl/wb_uart_cmd_master_if.sv
// UART byte stream and Wishbone classic master signals of wb_uart_cmd_master.
// The master modport is the command parser's view; slave is the bus/UART side.
interface wb_uart_cmd_master_if;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_err_i;
   logic        wbm_rty_i;
   logic        busy_o;

   modport master (
      input  rx_data_i, rx_valid_i, tx_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
      output tx_data_o, tx_valid_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
             wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o, busy_o
   );

   modport slave (
      output rx_data_i, rx_valid_i, tx_ready_i, wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
      input  tx_data_o, tx_valid_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
             wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o, busy_o
   );
endinterface

// File: rtl/wb_uart_cmd_master.sv
// UART 'W'/'R' command parser issuing single 32-bit Wishbone classic cycles; cyc one cycle after the
// last command byte, response byte(s) held until tx_ready_i. Define WB_UART_CMD_TIMEOUT_EN for the bus timeout.
module wb_uart_cmd_master #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic                  wb_clk_i,
   input logic                  wb_rst_i,
   wb_uart_cmd_master_if.master bus
);
   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] RSP_K = 8'h4B;
   localparam logic [7:0] RSP_E = 8'h45;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [31:0] rsp_q, rsp_d;
   logic        term, fail, expired;

   assign term = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;
   assign fail = bus.wbm_err_i | bus.wbm_rty_i;

`ifdef WB_UART_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   // Counter is zero on the first BUS cycle and counts every cycle spent there.
   assign tmo_d   = (state_q == S_BUS) ? tmo_q + 1'b1 : '0;
   assign expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) tmo_q <= '0;
      else          tmo_q <= tmo_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign expired        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rsp_d   = rsp_q;
      case (state_q)
         S_IDLE: begin
            if (bus.rx_valid_i && (bus.rx_data_i == CMD_W || bus.rx_data_i == CMD_R)) begin
               we_d    = (bus.rx_data_i == CMD_W);
               cnt_d   = 2'd0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (bus.rx_valid_i) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  adr_d   = {adr_q[23:0], bus.rx_data_i[7:2], 2'b00};
                  state_d = we_q ? S_DATA : S_BUS;
               end else begin
                  adr_d = {adr_q[23:0], bus.rx_data_i};
               end
            end
         end
         S_DATA: begin
            if (bus.rx_valid_i) begin
               cnt_d = cnt_q + 2'd1;
               dat_d = {dat_q[23:0], bus.rx_data_i};
               if (cnt_q == 2'd3) state_d = S_BUS;
            end
         end
         S_BUS: begin
            // err/rty outrank ack; a real termination outranks timeout expiry.
            if (term) begin
               state_d = S_RESP;
               cnt_d   = 2'd0;
               if (fail) begin
                  rsp_d = {RSP_E, 24'h0};
               end else if (we_q) begin
                  rsp_d = {RSP_K, 24'h0};
               end else begin
                  rsp_d = bus.wbm_dat_i;
                  cnt_d = 2'd3;
               end
            end else if (expired) begin
               state_d = S_RESP;
               cnt_d   = 2'd0;
               rsp_d   = {RSP_E, 24'h0};
            end
         end
         S_RESP: begin
            if (bus.tx_ready_i) begin
               if (cnt_q == 2'd0) begin
                  state_d = S_IDLE;
               end else begin
                  rsp_d = {rsp_q[23:0], 8'h00};
                  cnt_d = cnt_q - 2'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         cnt_q   <= 2'd0;
         adr_q   <= '0;
         dat_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rsp_q   <= rsp_d;
      end
   end

   assign bus.wbm_cyc_o  = (state_q == S_BUS);
   assign bus.wbm_stb_o  = bus.wbm_cyc_o;
   assign bus.wbm_sel_o  = bus.wbm_cyc_o ? 4'hF : 4'h0;
   assign bus.wbm_we_o   = we_q;
   assign bus.wbm_adr_o  = adr_q;
   assign bus.wbm_dat_o  = dat_q;
   assign bus.wbm_cti_o  = 3'b000;
   assign bus.wbm_bte_o  = 2'b00;
   assign bus.tx_valid_o = (state_q == S_RESP);
   assign bus.tx_data_o  = rsp_q[31:24];
   assign bus.busy_o     = (state_q != S_IDLE);
endmodule
